schmidl_cox_preamble_inserter: RTL and testbench
================================================

// Module: schmidl_cox_preamble_inserter
// PURPOSE
//  TX-side counterpart of the Schmidl-Cox detector. Prefixes every OFDM frame with a
//  2*HALF_LEN-sample preamble made of two identical halves, read from a writable table,
//  then passes FRAME_LEN payload samples. Sits in the ce_clk domain between the
//  payload source and the radio TX path. Output is sc16 AXI-Stream, with SOF and EOF marks.
// PARAMETERS
//  ITEM_W    32   sample width, sc16 {I[31:16],Q[15:0]}
//  HALF_LEN  128  preamble half length L in samples (power of 2, >=2)
//  LEN_W     16   width of frame_len
// PORTS
//  ce_clk         in   1               block clock; only clock
//  ce_rst         in   1               asynchronous, active-high reset
//  enable         in   1               allow new frames to start
//  frame_len      in   LEN_W           payload samples per frame, latched at frame start
//  pre_wr_en      in   1               preamble table write strobe
//  pre_wr_addr    in   $clog2(HALF_LEN) table address
//  pre_wr_data    in   ITEM_W          table sample
//  s_axis_tdata   in   ITEM_W          payload samples (s_axis_tlast not used)
//  s_axis_tvalid  in   1               payload valid
//  s_axis_tready  out  1               payload ready
//  m_axis_tdata   out  ITEM_W          framed output samples
//  m_axis_tuser   out  1               SOF: high on first preamble sample
//  m_axis_tlast   out  1               EOF: high on last sample of frame
//  m_axis_tvalid  out  1               output valid
//  m_axis_tready  in   1               output ready
//  busy           out  1               state != IDLE
//  frame_count    out  32              completed frames, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset (async assert, sync-to-ce_clk release): state=IDLE, sample index=0,
//    frame_count=0, and m_axis_tvalid, s_axis_tready, m_axis_tuser, m_axis_tlast, busy=0.
//    m_axis_tdata=0. Table contents are not reset.
//  - Table: written on pre_wr_en only in IDLE. Writes in any other state are dropped.
//    Reads are combinational, so the table drives m_axis_tdata with 0 latency.
//  - FSM (transfer = m_axis_tvalid && m_axis_tready):
//    IDLE: -> PRE_A when enable && s_axis_tvalid. Latch frame_len into len_q and clear the index.
//    PRE_A: m_axis_tvalid=1, data=table[idx]. On transfer idx++. At idx==L-1, -> PRE_B with idx=0.
//    PRE_B: same table replay. At idx==L-1: -> PAYLOAD with idx=0, or -> DONE if len_q==0.
//    PAYLOAD: pass-through, with s_axis_tready=m_axis_tready and m_axis_tvalid=s_axis_tvalid.
//      data=s_axis_tdata. On transfer idx++. At idx==len_q-1, -> DONE.
//    DONE (1 cycle, no output): frame_count++. -> PRE_A if enable && s_axis_tvalid,
//      otherwise -> IDLE. Frame_len is re-latched on every frame start.
//  - s_axis_tready=0 in every state except PAYLOAD.
//  - m_axis_tuser=1 only in PRE_A with idx==0.
//  - m_axis_tlast=1 on the final sample of the frame: the last PAYLOAD sample, or the last
//    PRE_B sample when len_q==0.
//  - Stall rule: while m_axis_tvalid && !m_axis_tready, tdata/tuser/tlast hold stable.
//    The preamble index is not advanced.
//  - Deasserting enable mid-frame has no effect on the current frame. It only blocks the next start.
//  - Changing frame_len mid-frame has no effect on the current frame.
//  - Payload underrun (s_axis_tvalid low in PAYLOAD): m_axis_tvalid drops, the FSM waits, and no
//    padding is inserted.
//  - Reset mid-frame: immediate return to IDLE. The partial frame is truncated and is not counted.
//  - Counters: idx is $clog2(HALF_LEN) bits in the preamble states and LEN_W bits in PAYLOAD.
//  - Worst-case throughput: 1 sample/cycle, plus 1 DONE bubble per frame.
// TESTING
//  1. HALF_LEN=8, table[k]=0x00010000+k, frame_len=16, payload 0xA000+n, tready=1
//     -> 32 beats: table 0..7 twice, then 0xA000..0xA00F. tuser on beat 0, tlast on beat 31,
//     frame_count=1.
//  2. Same frame with 25% random m_axis_tready stalls and 25% s_axis_tvalid gaps
//     -> identical beat sequence, with data held stable on every stall.
//  3. frame_len=0 -> 16 preamble beats only, tlast on beat 15, s_axis_tready never high.
//  4. Three back-to-back frames, with frame_len changed 16->4 during frame 1
//     -> frames of 16, 4, 4 payload samples. One idle cycle between frames. frame_count=3.
//  5. Write table[3]=0xDEADBEEF during PRE_B, then run the next frame
//     -> the write is ignored and beat 3 still equals 0x00010003.
//  6. Assert ce_rst at beat 10 of a frame -> outputs go to 0 asynchronously and frame_count=0.
//     After release, the next frame starts with tuser.

Source files
------------

// File: rtl/schmidl_cox_preamble_inserter.sv
`default_nettype none
// ============================================================================
// Module   : schmidl_cox_preamble_inserter
// Purpose  : Puts a Schmidl-Cox preamble in front of every OFDM frame. The
//            preamble is two identical halves of HALF_LEN samples, replayed
//            from a writable table. After the preamble come frame_len payload
//            samples. The output is sc16 AXI-Stream with SOF (tuser) and EOF
//            (tlast) marks.
// Ports    : ce_clk/ce_rst          clock, async active-high reset
//            enable, frame_len      frame start gate, payload length
//            pre_wr_*               preamble table write port (IDLE only)
//            s_axis_*               payload input stream
//            m_axis_*               framed output stream (tuser=SOF, tlast=EOF)
//            busy, frame_count      status
// Revision : 1.0  initial release
// ============================================================================
module schmidl_cox_preamble_inserter #(
  parameter int ITEM_W   = 32,
  parameter int HALF_LEN = 128,
  parameter int LEN_W    = 16
) (
  input  logic                        ce_clk,
  input  logic                        ce_rst,
  input  logic                        enable,
  input  logic [LEN_W-1:0]            frame_len,
  input  logic                        pre_wr_en,
  input  logic [$clog2(HALF_LEN)-1:0] pre_wr_addr,
  input  logic [ITEM_W-1:0]           pre_wr_data,
  input  logic [ITEM_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [ITEM_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic [31:0]                 frame_count
);

  localparam int AW = $clog2(HALF_LEN);
  localparam logic [AW-1:0] PRE_LAST = AW'(HALF_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE_A   = 3'd1,
    S_PRE_B   = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      pre_idx, pre_idx_nxt;
  logic [LEN_W-1:0]   pay_idx, pay_idx_nxt;
  logic [LEN_W-1:0]   len_q, len_q_nxt;
  logic               count_inc;

  logic [ITEM_W-1:0]  pre_table [HALF_LEN];

  // Table is only writable while idle so a frame in flight always replays
  // one consistent preamble. Contents survive reset.
  always_ff @(posedge ce_clk) begin
    if (pre_wr_en && (state == S_IDLE)) begin
      pre_table[pre_wr_addr] <= pre_wr_data;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state       <= S_IDLE;
      pre_idx     <= '0;
      pay_idx     <= '0;
      len_q       <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      pre_idx     <= pre_idx_nxt;
      pay_idx     <= pay_idx_nxt;
      len_q       <= len_q_nxt;
      if (count_inc) begin
        frame_count <= frame_count + 32'd1;
      end
    end
  end

  // Outputs are decoded from the registered state/index, so an async reset
  // forces them to zero immediately. Indices only move on a transfer, which
  // keeps tdata/tuser/tlast stable across a stall.
  always_comb begin
    state_nxt     = state;
    pre_idx_nxt   = pre_idx;
    pay_idx_nxt   = pay_idx;
    len_q_nxt     = len_q;
    count_inc     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = 1'b0;
    m_axis_tlast  = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable && s_axis_tvalid) begin
          state_nxt   = S_PRE_A;
          len_q_nxt   = frame_len;
          pre_idx_nxt = '0;
          pay_idx_nxt = '0;
        end
      end

      S_PRE_A: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pre_table[pre_idx];
        m_axis_tuser  = (pre_idx == '0);
        if (m_axis_tready) begin
          if (pre_idx == PRE_LAST) begin
            pre_idx_nxt = '0;
            state_nxt   = S_PRE_B;
          end else begin
            pre_idx_nxt = pre_idx + AW'(1);
          end
        end
      end

      S_PRE_B: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pre_table[pre_idx];
        // A zero-length frame ends on the last preamble sample.
        m_axis_tlast  = (pre_idx == PRE_LAST) && (len_q == '0);
        if (m_axis_tready) begin
          if (pre_idx == PRE_LAST) begin
            pre_idx_nxt = '0;
            pay_idx_nxt = '0;
            state_nxt   = (len_q == '0) ? S_DONE : S_PAYLOAD;
          end else begin
            pre_idx_nxt = pre_idx + AW'(1);
          end
        end
      end

      S_PAYLOAD: begin
        // Straight pass-through; an input underrun simply drops tvalid.
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = (pay_idx == (len_q - LEN_W'(1)));
        if (s_axis_tvalid && m_axis_tready) begin
          if (pay_idx == (len_q - LEN_W'(1))) begin
            pay_idx_nxt = '0;
            state_nxt   = S_DONE;
          end else begin
            pay_idx_nxt = pay_idx + LEN_W'(1);
          end
        end
      end

      S_DONE: begin
        count_inc = 1'b1;
        if (enable && s_axis_tvalid) begin
          state_nxt   = S_PRE_A;
          len_q_nxt   = frame_len;
          pre_idx_nxt = '0;
          pay_idx_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_schmidl_cox_preamble_inserter.sv
`default_nettype none
// ============================================================================
// Module   : tb_schmidl_cox_preamble_inserter
// Purpose  : Scoreboard bench for schmidl_cox_preamble_inserter (HALF_LEN=8).
//            Each planned frame pushes its expected beats (preamble table
//            twice, then the payload words handed to the source) into a queue;
//            a monitor pops and compares on every output transfer and checks
//            that stalled beats hold stable.
// Revision : 1.0  initial release
// ============================================================================
module tb_schmidl_cox_preamble_inserter;

  localparam int H = 8;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] frame_len = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tuser, m_tlast, m_tvalid;
  logic        m_tready = 1'b0;
  logic        busy;
  logic [31:0] frame_count;

  schmidl_cox_preamble_inserter #(.ITEM_W(32), .HALF_LEN(H), .LEN_W(16)) dut (
    .ce_clk(clk), .ce_rst(rst), .enable(enable), .frame_len(frame_len),
    .pre_wr_en(wr_en), .pre_wr_addr(wr_addr), .pre_wr_data(wr_data),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] tbl[H];
  logic [31:0] pay_next;
  int          exp_fc = 0;
  int          beats = 0;
  int          bubbles = 0;
  int          stall_pct = 0;
  int          gap_pct = 0;
  bit          saw_sready = 0;
  bit          saw_busy = 0;
  bit          src_fire = 0;
  bit          hold_v = 0;
  beat_t       hold_b;
  beat_t       cur_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload source and sink back-pressure, updated just after each edge.
  // A presented source word is held until it is accepted.
  always @(posedge clk) begin
    bit fired;
    #1;
    fired = src_fire;
    if (fired && src_q.size() > 0) void'(src_q.pop_front());
    m_tready = ($urandom_range(0, 99) >= stall_pct);
    if (src_q.size() == 0) s_tvalid = 1'b0;
    else if (!(s_tvalid && !fired)) s_tvalid = ($urandom_range(0, 99) >= gap_pct);
    s_tdata = (src_q.size() > 0) ? src_q[0] : 32'h0;
  end

  // Monitor: sampled mid-cycle; a valid&&ready seen here transfers at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_v   = 0;
      src_fire = 0;
    end else begin
      cur_b = '{d: m_tdata, u: m_tuser, l: m_tlast};
      if (hold_v && m_tvalid) chk($sformatf("stall_hold%0d", beats), cur_b, hold_b);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected no beat", cur_b);
        end else begin
          chk($sformatf("beat%0d", beats), cur_b, exp_q.pop_front());
        end
        beats++;
      end
      hold_v   = m_tvalid && !m_tready;
      hold_b   = cur_b;
      src_fire = s_tvalid && s_tready;
      if (s_tready) saw_sready = 1;
      if (busy) saw_busy = 1;
      if (busy && !m_tvalid) bubbles++;
    end
  end

  // Expected frame: table twice (SOF on first), then len fresh payload words.
  task automatic push_frame(input int len);
    logic [31:0] v;
    for (int k = 0; k < 2 * H; k++)
      exp_q.push_back('{d: tbl[k % H], u: (k == 0), l: (len == 0 && k == 2 * H - 1)});
    for (int n = 0; n < len; n++) begin
      v = pay_next;
      pay_next = pay_next + 32'd1;
      src_q.push_back(v);
      exp_q.push_back('{d: v, u: 1'b0, l: (n == len - 1)});
    end
    exp_fc++;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_beats(input int b0, input int cnt, input string name);
    int n = 0;
    while ((beats - b0) < cnt && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk({name, "_beat_timeout"}, beats - b0, cnt);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    chk({name, "_drained"}, exp_q.size(), 0);
    if (n >= 3000) chk({name, "_done_timeout"}, busy, 0);
  endtask

  task automatic tbl_write(input int a, input logic [31:0] d, input bit model);
    @(posedge clk); #2;
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    @(posedge clk); #2;
    wr_en = 1'b0;
    if (model) tbl[a] = d;
  endtask

  // One isolated frame; a zero-length frame needs a word on s_axis to start.
  task automatic run_frame(input int len, input string name);
    frame_len = 16'(len);
    push_frame(len);
    if (len == 0) src_q.push_back(32'h0BAD0000);
    enable = 1'b1;
    wait_busy(name);
    enable = 1'b0;
    wait_done(name);
    if (len == 0) src_q.delete();
  endtask

  initial begin
    int b0;
    int len;
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    int len;
    for (int k = 0; k < H; k++) tbl[k] = 32'h00010000 + k;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_tuser_tlast", {m_tuser, m_tlast}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_frame_count", frame_count, 0);
    for (int k = 0; k < H; k++) tbl_write(k, 32'h00010000 + k, 1);

    // Basic frame, no stalls.
    pay_next = 32'hA000;
    run_frame(16, "t1");
    chk("t1_frame_count", frame_count, exp_fc);

    // With enable low, available payload must not start a frame.
    saw_busy = 0;
    src_q.push_back(32'h12345678);
    repeat (20) @(negedge clk);
    chk("enable_blocks", saw_busy, 0);
    src_q.delete();

    // Same frame with sink stalls and source gaps.
    stall_pct = 25; gap_pct = 25;
    pay_next = 32'hA000;
    run_frame(16, "t2");
    chk("t2_frame_count", frame_count, exp_fc);

    // Zero-length frame: preamble only, payload never accepted.
    stall_pct = 0; gap_pct = 0;
    saw_sready = 0;
    run_frame(0, "t3");
    chk("t3_no_sready", saw_sready, 0);
    chk("t3_frame_count", frame_count, exp_fc);

    // Back-to-back frames; frame_len changes while the first is in flight.
    frame_len = 16'd16;
    push_frame(16); push_frame(4); push_frame(4);
    bubbles = 0;
    enable = 1'b1;
    wait_busy("t4");
    frame_len = 16'd4;
    wait_done("t4");
    enable = 1'b0;
    chk("t4_bubbles", bubbles, 3);
    chk("t4_frame_count", frame_count, exp_fc);

    // Table write during PRE_B is dropped.
    frame_len = 16'd4;
    push_frame(4);
    b0 = beats;
    enable = 1'b1;
    wait_beats(b0, 10, "t5");
    tbl_write(3, 32'hDEADBEEF, 0);
    enable = 1'b0;
    wait_done("t5a");
    run_frame(4, "t5b");
    chk("t5_frame_count", frame_count, exp_fc);

    // Randomized frames with fresh table contents, stalls and gaps.
    for (int r = 0; r < 6; r++) begin
      tbl_write($urandom_range(0, H - 1), $urandom, 1);
      tbl_write($urandom_range(0, H - 1), $urandom, 1);
      stall_pct = 25; gap_pct = 25;
      len = $urandom_range(0, 12);
      run_frame(len, $sformatf("rnd%0d", r));
    end
    chk("rnd_frame_count", frame_count, exp_fc);

    // Reset in the middle of the preamble truncates the frame.
    stall_pct = 0; gap_pct = 0;
    frame_len = 16'd16;
    push_frame(16);
    b0 = beats;
    enable = 1'b1;
    wait_beats(b0, 10, "t6");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", m_tvalid, 0);
    chk("t6_rst_tdata", m_tdata, 0);
    chk("t6_rst_tuser_tlast", {m_tuser, m_tlast}, 0);
    chk("t6_rst_busy_sready", {busy, s_tready}, 0);
    chk("t6_rst_frame_count", frame_count, 0);
    exp_q.delete();
    src_q.delete();
    exp_fc = 0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run_frame(2, "t6_after");
    chk("t6_frame_count", frame_count, exp_fc);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
